// File: rtl/npc_pkg.sv
// Shared decode constants for the NPC core: major opcodes, the EBREAK word,
// the ALU operation encoding and the decoded control bundle.
package npc_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SLT   = 4'd1,
        ALU_SLTU  = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_AND   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_PASSB = 4'd9
    } alu_op_e;

    // Width-independent part of the decoded bundle; pc and imm live beside it.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rd;
        alu_op_e    alu_op;
        logic       a_pc;
        logic       reg_wr;
        logic       jump;
        logic       ebreak;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/idu_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave is the decode stage's view; master is the surrounding core's view.
interface idu_pipe_if #(
    parameter int XLEN     = 64,
    parameter int ALU_OP_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [31:0]         in_inst;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rd;
    logic [XLEN-1:0]     out_imm;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic                out_a_pc;
    logic                out_reg_wr;
    logic                out_jump;
    logic                out_ebreak;
    logic                out_illegal;

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rd, out_imm,
               out_alu_op, out_a_pc, out_reg_wr, out_jump, out_ebreak, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rd, out_imm,
               out_alu_op, out_a_pc, out_reg_wr, out_jump, out_ebreak, out_illegal
    );
endinterface

// File: rtl/idu_dec.sv
// Combinational RV32I/RV64I decoder for OP-IMM, LUI, AUIPC, JAL, JALR, EBREAK.
// Anything else yields an all-zero bundle with only illegal set.
module idu_dec
    import npc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic signed [11:0] imm_i;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [5:0]         shamt;
    logic               shamt_ok;
    logic               bad;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign imm_i  = inst[31:20];
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // RV32 has a 5-bit shamt, so inst[25] joins the must-be-zero funct bits.
    assign shamt    = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
    assign shamt_ok = ((inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000))
                      && ((XLEN == 64) || !inst[25]);

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        ctrl = '0;
        imm  = '0;
        bad  = 1'b0;
        case (opcode)
            OP_IMM: begin
                ctrl.rd     = inst[11:7];
                ctrl.rs1    = inst[19:15];
                ctrl.reg_wr = 1'b1;
                imm         = XLEN'(imm_i);
                case (funct3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b110: ctrl.alu_op = ALU_OR;
                    3'b111: ctrl.alu_op = ALU_AND;
                    3'b001: begin
                        ctrl.alu_op = ALU_SLL;
                        imm         = XLEN'(shamt);
                        bad         = !shamt_ok;
                    end
                    default: begin
                        ctrl.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                        imm         = XLEN'(shamt);
                        bad         = !shamt_ok;
                    end
                endcase
            end
            LUI: begin
                ctrl.rd     = inst[11:7];
                ctrl.reg_wr = 1'b1;
                ctrl.alu_op = ALU_PASSB;
                imm         = XLEN'(imm_u);
            end
            AUIPC: begin
                ctrl.rd     = inst[11:7];
                ctrl.reg_wr = 1'b1;
                ctrl.a_pc   = 1'b1;
                imm         = XLEN'(imm_u);
            end
            JAL: begin
                ctrl.rd     = inst[11:7];
                ctrl.reg_wr = 1'b1;
                ctrl.a_pc   = 1'b1;
                ctrl.jump   = 1'b1;
                imm         = XLEN'(imm_j);
            end
            JALR: begin
                ctrl.rd     = inst[11:7];
                ctrl.rs1    = inst[19:15];
                ctrl.reg_wr = 1'b1;
                ctrl.a_pc   = 1'b1;
                ctrl.jump   = 1'b1;
                imm         = XLEN'(imm_i);
                bad         = (funct3 != 3'b000);
            end
            SYSTEM: begin
                if (inst == EBREAK_WORD) ctrl.ebreak = 1'b1;
                else                     bad         = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            imm          = '0;
        end
    end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage: one output register plus a one-entry skid buffer holding
// decoded bundles, so backpressure never drops or reorders instructions.
module idu_pipe
    import npc_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ALU_OP_W = 4
) (
    input logic       clk,
    input logic       rstn,
    idu_pipe_if.slave bus
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    logic            out_valid_q;
    ctrl_t           out_ctrl;
    logic [XLEN-1:0] out_imm_q;
    logic [XLEN-1:0] out_pc_q;

    logic            skid_valid;
    ctrl_t           skid_ctrl;
    logic [XLEN-1:0] skid_imm;
    logic [XLEN-1:0] skid_pc;

    logic accept;
    logic out_free;

    idu_dec #(.XLEN(XLEN)) u_dec (
        .inst (bus.in_inst),
        .ctrl (dec_ctrl),
        .imm  (dec_imm)
    );

    assign accept   = bus.in_valid && bus.in_ready;
    assign out_free = !out_valid_q || bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
            out_ctrl    <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_q <= 1'b1;
                skid_valid  <= 1'b0;
                out_ctrl    <= skid_ctrl;
                out_imm_q   <= skid_imm;
                out_pc_q    <= skid_pc;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    out_ctrl  <= dec_ctrl;
                    out_imm_q <= dec_imm;
                    out_pc_q  <= dec_pc_sel();
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] dec_pc_sel();
        return bus.in_pc;
    endfunction

    // NOTE: the skid payload has no reset; skid_valid alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (accept && !out_free) begin
            skid_ctrl <= dec_ctrl;
            skid_imm  <= dec_imm;
            skid_pc   <= bus.in_pc;
        end
    end

    assign bus.in_ready    = rstn && !skid_valid;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_rs1     = out_ctrl.rs1;
    assign bus.out_rd      = out_ctrl.rd;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_alu_op  = ALU_OP_W'(out_ctrl.alu_op);
    assign bus.out_a_pc    = out_ctrl.a_pc;
    assign bus.out_reg_wr  = out_ctrl.reg_wr;
    assign bus.out_jump    = out_ctrl.jump;
    assign bus.out_ebreak  = out_ctrl.ebreak;
    assign bus.out_illegal = out_ctrl.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: an XLEN=64 and an XLEN=32 instance share one stimulus.
// The 64-bit stream is checked every cycle against a FIFO-of-decoded-words model.
module tb_idu_pipe;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    idu_pipe_if #(.XLEN(64), .ALU_OP_W(4)) b64 ();
    idu_pipe_if #(.XLEN(32), .ALU_OP_W(4)) b32 ();

    idu_pipe #(.XLEN(64), .ALU_OP_W(4)) dut64 (.clk(clk), .rstn(rstn), .bus(b64));
    idu_pipe #(.XLEN(32), .ALU_OP_W(4)) dut32 (.clk(clk), .rstn(rstn), .bus(b32));

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [63:0] imm;
        int          alu;
        bit          a_pc;
        bit          reg_wr;
        bit          jump;
        bit          ebreak;
        bit          illegal;
    } exp_t;

    exp_t        q[$];
    logic [63:0] emerged[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          zeroed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode straight from the ISA field definitions with integer arithmetic.
    function automatic exp_t model(input logic [63:0] pc, input logic [31:0] w);
        exp_t e;
        int   op, f3, j;
        bit   ok;
        int   alu_tab[8];
        alu_tab = '{0, 6, 1, 2, 3, 7, 4, 5};
        e = '{pc: pc, rs1: 0, rd: 0, imm: 0, alu: 0, a_pc: 0, reg_wr: 0, jump: 0, ebreak: 0, illegal: 0};
        op = int'(w & 32'h7F);
        f3 = int'((w >> 12) & 32'h7);
        ok = 1'b0;
        if (op == 'h13) begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.reg_wr = 1;
            e.alu = alu_tab[f3];
            if (f3 == 1 || f3 == 5) begin
                ok = (w[31:26] == 6'd0) || (w[31:26] == 6'd16);
                if (f3 == 5 && w[30]) e.alu = 8;
                e.imm = 64'(w[25:20]);
            end else begin
                ok = 1'b1;
                e.imm = longint'($signed(w)) >>> 20;
            end
        end else if (op == 'h37 || op == 'h17) begin
            ok = 1'b1;
            e.rd = w[11:7]; e.reg_wr = 1;
            e.imm = longint'($signed(w & 32'hFFFF_F000));
            if (op == 'h37) e.alu = 9; else e.a_pc = 1;
        end else if (op == 'h6F) begin
            ok = 1'b1;
            e.rd = w[11:7]; e.reg_wr = 1; e.a_pc = 1; e.jump = 1;
            j = int'((((w >> 31) & 1) << 20) | (((w >> 12) & 'hFF) << 12)
                   | (((w >> 20) & 1) << 11) | (((w >> 21) & 'h3FF) << 1));
            if (j >= (1 << 20)) j = j - (1 << 21);
            e.imm = longint'(j);
        end else if (op == 'h67) begin
            ok = (f3 == 0);
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.reg_wr = 1; e.a_pc = 1; e.jump = 1;
            e.imm = longint'($signed(w)) >>> 20;
        end else if (w == 32'h0010_0073) begin
            ok = 1'b1;
            e.ebreak = 1;
        end
        if (!ok) e = '{pc: pc, rs1: 0, rd: 0, imm: 0, alu: 0, a_pc: 0, reg_wr: 0, jump: 0, ebreak: 0, illegal: 1};
        return e;
    endfunction

    // Compare process: outputs are stable at negedge; afterwards advance the model
    // to what the coming posedge must do.
    always @(negedge clk) begin
        if (!rstn) begin
            check("in_ready_in_reset", 64'(b64.in_ready), 64'd0);
            if (zeroed) begin
                check("rst_pc_imm", b64.out_pc | b64.out_imm, 64'd0);
                check("rst_ctrl", 64'({b64.out_valid, b64.out_rs1, b64.out_rd, b64.out_alu_op,
                      b64.out_a_pc, b64.out_reg_wr, b64.out_jump, b64.out_ebreak, b64.out_illegal}), 64'd0);
            end
        end else begin
            check("out_valid", 64'(b64.out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(b64.in_ready), 64'(q.size() < 2));
            if (b64.out_valid && q.size() > 0) begin
                check("out_pc", b64.out_pc, q[0].pc);
                check("out_imm", b64.out_imm, q[0].imm);
                check("out_ctrl", 64'({b64.out_rs1, b64.out_rd, b64.out_alu_op, b64.out_a_pc,
                      b64.out_reg_wr, b64.out_jump, b64.out_ebreak, b64.out_illegal}),
                      64'({q[0].rs1, q[0].rd, 4'(q[0].alu), q[0].a_pc,
                      q[0].reg_wr, q[0].jump, q[0].ebreak, q[0].illegal}));
            end
        end

        if (!rstn) begin
            q.delete();
            zeroed = 1'b1;
        end else begin
            zeroed = 1'b0;
            if (b64.flush) begin
                q.delete();
            end else begin
                bit take;
                take = b64.in_valid && (q.size() < 2);
                if (b64.out_ready && q.size() > 0) begin
                    emerged.push_back(q[0].pc);
                    void'(q.pop_front());
                end
                if (take) q.push_back(model(b64.in_pc, b64.in_inst));
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst);
        b64.in_valid = v; b64.in_pc = pc;        b64.in_inst = inst;
        b32.in_valid = v; b32.in_pc = pc[31:0];  b32.in_inst = inst;
    endtask

    task automatic set_ordy(input logic r);
        b64.out_ready = r; b32.out_ready = r;
    endtask

    task automatic set_flush(input logic f);
        b64.flush = f; b32.flush = f;
    endtask

    // Offer one instruction and return at posedge+1 after the edge that takes it.
    task automatic send(input logic [63:0] pc, input logic [31:0] inst);
        drive(1'b1, pc, inst);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (b64.in_ready) break;
            if (t == 59) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: pc %h never accepted", pc);
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 64'd0, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    logic [31:0] vec[14];

    initial begin
        drive(1'b0, 64'd0, 32'd0);
        set_ordy(1'b1);
        set_flush(1'b0);
        vec = '{32'h0050A213, 32'h80013313, 32'h7FF3C393, 32'h00106413, 32'h0F047493,
                32'h0015D593, 32'h8015D593, 32'h12345617, 32'h00008067, 32'h00009067,
                32'h00000073, 32'h00000033, 32'hFFFFFFFF, 32'h43F1D113};
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Hand-computed decodes, one at a time with out_ready high.
        send(64'h1000, 32'hFFF00093);
        @(negedge clk);
        check("addi_valid", 64'(b64.out_valid), 64'd1);
        check("addi_rd", 64'(b64.out_rd), 64'd1);
        check("addi_rs1", 64'(b64.out_rs1), 64'd0);
        check("addi_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_alu", 64'(b64.out_alu_op), 64'd0);
        check("addi_reg_wr", 64'(b64.out_reg_wr), 64'd1);
        check("addi_imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
        next_cycle();

        send(64'h1004, 32'h800002B7);
        @(negedge clk);
        check("lui_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_alu", 64'(b64.out_alu_op), 64'd9);
        check("lui_imm32", 64'(b32.out_imm), 64'h8000_0000);
        next_cycle();

        send(64'h1008, 32'h00100073);
        @(negedge clk);
        check("ebreak_flag", 64'(b64.out_ebreak), 64'd1);
        check("ebreak_reg_wr", 64'(b64.out_reg_wr), 64'd0);
        check("ebreak_illegal", 64'(b64.out_illegal), 64'd0);
        next_cycle();

        send(64'h100C, 32'h43F1D113);
        @(negedge clk);
        check("srai_alu", 64'(b64.out_alu_op), 64'd8);
        check("srai_imm", b64.out_imm, 64'd63);
        check("srai32_illegal", 64'(b32.out_illegal), 64'd1);
        check("srai32_reg_wr", 64'(b32.out_reg_wr), 64'd0);
        next_cycle();

        send(64'h1010, 32'h02151513);
        @(negedge clk);
        check("slli33_alu", 64'(b64.out_alu_op), 64'd6);
        check("slli33_imm", b64.out_imm, 64'd33);
        check("slli33_32_illegal", 64'(b32.out_illegal), 64'd1);
        next_cycle();

        send(64'h1014, 32'hFFDFF0EF);
        @(negedge clk);
        check("jal_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("jal_flags", 64'({b64.out_jump, b64.out_a_pc, b64.out_reg_wr}), 64'b111);
        check("jal_rs1", 64'(b64.out_rs1), 64'd0);
        next_cycle();

        // Remaining encodings, with a repeating out_ready stall pattern.
        foreach (vec[i]) begin
            set_ordy((i % 3) != 2);
            send(64'h1100 + 64'(4 * i), vec[i]);
        end
        set_ordy(1'b1);
        repeat (4) next_cycle();

        // Backpressure: A in output, B in skid, C held off.
        emerged.delete();
        set_ordy(1'b0);
        send(64'h2000, 32'h00100093);
        send(64'h2004, 32'h00200113);
        drive(1'b1, 64'h2008, 32'h00300193);
        @(negedge clk);
        check("bp_in_ready", 64'(b64.in_ready), 64'd0);
        check("bp_hold_pc", b64.out_pc, 64'h2000);
        next_cycle();
        @(negedge clk);
        check("bp_hold_pc2", b64.out_pc, 64'h2000);
        next_cycle();
        set_ordy(1'b1);
        send(64'h2008, 32'h00300193);
        repeat (4) next_cycle();
        check("bp_count", 64'(emerged.size()), 64'd3);
        check("bp_first", emerged.size() > 0 ? emerged[0] : 64'hX, 64'h2000);
        check("bp_second", emerged.size() > 1 ? emerged[1] : 64'hX, 64'h2004);
        check("bp_third", emerged.size() > 2 ? emerged[2] : 64'hX, 64'h2008);

        // Flush with output and skid full plus a pending input.
        set_ordy(1'b0);
        send(64'h3000, 32'h00100093);
        send(64'h3004, 32'h00200113);
        drive(1'b1, 64'h3008, 32'h00300193);
        set_flush(1'b1);
        next_cycle();
        set_flush(1'b0);
        drive(1'b0, 64'd0, 32'd0);
        @(negedge clk);
        check("flush_out_valid", 64'(b64.out_valid), 64'd0);
        check("flush_in_ready", 64'(b64.in_ready), 64'd1);
        next_cycle();

        // Flush while the stage could still accept: the same-cycle input is dropped.
        send(64'h3010, 32'h00100093);
        drive(1'b1, 64'h3014, 32'h00200113);
        set_flush(1'b1);
        next_cycle();
        set_flush(1'b0);
        drive(1'b0, 64'd0, 32'd0);
        @(negedge clk);
        check("flush2_out_valid", 64'(b64.out_valid), 64'd0);
        next_cycle();
        emerged.delete();
        set_ordy(1'b1);
        send(64'h3020, 32'h00500293);
        repeat (3) next_cycle();
        check("flush_next_count", 64'(emerged.size()), 64'd1);
        check("flush_next_pc", emerged.size() > 0 ? emerged[0] : 64'hX, 64'h3020);

        // Reset mid-stall with the skid full; flush and input asserted too.
        set_ordy(1'b0);
        send(64'h4000, 32'h00100093);
        send(64'h4004, 32'h00200113);
        rstn = 1'b0;
        set_flush(1'b1);
        drive(1'b1, 64'h4008, 32'h00300193);
        @(negedge clk);
        check("rst_in_ready", 64'(b64.in_ready), 64'd0);
        next_cycle();
        @(negedge clk);
        check("rst_out_valid", 64'(b64.out_valid), 64'd0);
        check("rst_out_pc", b64.out_pc, 64'd0);
        next_cycle();
        rstn = 1'b1;
        set_flush(1'b0);
        drive(1'b0, 64'd0, 32'd0);
        @(negedge clk);
        check("post_rst_in_ready", 64'(b64.in_ready), 64'd1);
        check("post_rst_out_valid", 64'(b64.out_valid), 64'd0);
        next_cycle();
        set_ordy(1'b1);
        send(64'h5000, 32'h00000013);
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
